// File: rtl/data_mem_ctrl_if.sv
// ============================================================================
// Module   : data_mem_ctrl_if
// Brief    : Pipeline-side and RAM-side bus bundle for data_mem_ctrl.
//            Err exists only when DATA_MEM_CTRL_ALIGN_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_ctrl_if #(
    parameter int N = 6,
    parameter int W = 32
);
    logic           Req;
    logic           We;
    logic [1:0]     Size;
    logic           Uns;
    logic [N+1:0]   Addr;
    logic [W-1:0]   WData;
    logic [W-1:0]   RData;
    logic           Stall;
    logic           Done;
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    logic           Err;
`endif
    logic [N-1:0]   RamAd;
    logic [W-1:0]   RamDin;
    logic           RamEn;
    logic [W-1:0]   RamDout;

    modport slave (
        input  Req, We, Size, Uns, Addr, WData, RamDout,
        output RData, Stall, Done, RamAd, RamDin, RamEn
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
        , output Err
`endif
    );

    modport master (
        output Req, We, Size, Uns, Addr, WData, RamDout,
        input  RData, Stall, Done, RamAd, RamDin, RamEn
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
        , input Err
`endif
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Byte/half/word load-store controller over a word-wide async RAM,
//            sub-word stores done as read-modify-write.
//            Optional macro: DATA_MEM_CTRL_ALIGN_CHECK_EN (misalignment check).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter int N = 6,
    parameter int W = 32
) (
    input  wire logic        Clk,
    input  wire logic        Reset,
    data_mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic           r_we;
    logic [1:0]     r_size;
    logic           r_uns;
    logic [N+1:0]   r_addr;
    logic [W-1:0]   r_wdata;
    logic [W-1:0]   r_rbuf;
    logic [W-1:0]   r_rdata;

    logic           w_accept;
    logic           w_misalign;
    logic [1:0]     w_off;
    logic [1:0]     w_half_lane;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [W-1:0]   w_load;
    logic [W-1:0]   w_merge;

    assign w_accept = (r_state == IDLE) && bus.Req;
    assign w_off    = r_addr[1:0];

`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    logic           r_err;

    assign w_misalign = (bus.Size[1] && (bus.Addr[1:0] != 2'b00)) ||
                        ((bus.Size == 2'b01) && (bus.Addr[1:0] == 2'b11));
    assign bus.Err    = (r_state == DONE) && r_err && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Half lanes: offset 0 -> bytes 1:0, 1 -> bytes 2:1, 2/3 -> bytes 3:2
    always_comb begin
        w_half_lane = 2'd2;
        if (w_off == 2'd0) begin
            w_half_lane = 2'd0;
        end else if (w_off == 2'd1) begin
            w_half_lane = 2'd1;
        end
    end

    assign w_byte = bus.RamDout[{w_off, 3'b000} +: 8];
    assign w_half = bus.RamDout[{w_half_lane, 3'b000} +: 16];

    always_comb begin
        w_load = bus.RamDout;
        case (r_size)
            2'b00:   w_load = r_uns ? {{(W-8){1'b0}}, w_byte}
                                    : {{(W-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {{(W-16){1'b0}}, w_half}
                                    : {{(W-16){w_half[15]}}, w_half};
            default: w_load = bus.RamDout;
        endcase
    end

    always_comb begin
        w_merge = r_rbuf;
        if (r_size == 2'b00) begin
            w_merge[{w_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{w_half_lane, 3'b000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.Req) begin
                    if (w_misalign) begin
                        w_next = DONE;
                    end else if (bus.We && bus.Size[1]) begin
                        w_next = WRITE;
                    end else begin
                        w_next = READ;
                    end
                end
            end
            READ:    w_next = r_we ? WRITE : DONE;
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rbuf  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.We;
                r_size  <= bus.Size;
                r_uns   <= bus.Uns;
                r_addr  <= bus.Addr;
                r_wdata <= bus.WData;
            end
            // Leaving READ: loads go to DONE, so RData updates only for loads
            if (r_state == READ) begin
                r_rbuf <= bus.RamDout;
                if (!r_we) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign bus.RamAd  = r_addr[N+1:2];
    assign bus.RamDin = r_size[1] ? r_wdata : w_merge;
    assign bus.RamEn  = (r_state == WRITE) && !Reset;
    assign bus.RData  = r_rdata;
    assign bus.Done   = (r_state == DONE) && !Reset;
    assign bus.Stall  = ((r_state == IDLE) && bus.Req) ||
                        (r_state == READ) || (r_state == WRITE);

endmodule

`default_nettype wire
